// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble binary-to-packed-BCD converter, one input bit per clock.
// Define BIN2BCD_HEX_BYPASS_EN to add i_hex, which loads i_bin straight into o_bcd for raw hex display.
module bin2bcd_seq #(
  parameter int IN_W = 32,
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                i_start,
`ifdef BIN2BCD_HEX_BYPASS_EN
  input  logic                i_hex,
`endif
  input  logic [IN_W-1:0]     i_bin,
  output logic                o_busy,
  output logic                o_valid,
  output logic                o_ovf,
  output logic [4*DIGITS-1:0] o_bcd
);
  localparam int BW = 4*DIGITS;
  localparam int CW = $clog2(IN_W);
  localparam logic [IN_W-1:0] MAX_VAL = IN_W'(10**DIGITS - 1);
  typedef enum logic {IDLE, CONV} state_t;
  state_t state, state_nx;
  logic [IN_W-1:0] bin;
  logic [BW-1:0] bcd, adj;
  logic [CW-1:0] count;
  logic ovf_pending, last, hex;
`ifdef BIN2BCD_HEX_BYPASS_EN
  assign hex = i_hex;
`else
  assign hex = 1'b0;
`endif
  assign last = count == CW'(IN_W-1);
  for (genvar d = 0; d < DIGITS; d++) begin : g_adj
    assign adj[4*d+:4] = bcd[4*d+:4] >= 4'd5 ? bcd[4*d+:4] + 4'd3 : bcd[4*d+:4];
  end
  always_comb begin
    state_nx = state;
    if (state == IDLE)
      state_nx = i_start && !hex ? CONV : IDLE;
    else
      state_nx = last ? IDLE : CONV;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      bin         <= '0;
      bcd         <= '0;
      ovf_pending <= 1'b0;
      o_bcd       <= '0;
      o_valid     <= 1'b0;
      o_busy      <= 1'b0;
      o_ovf       <= 1'b0;
    end else begin
      state   <= state_nx;
      o_valid <= 1'b0;
      if (state == IDLE && i_start) begin
        if (hex) begin
          o_bcd   <= i_bin[BW-1:0];
          o_ovf   <= 1'b0;
          o_valid <= 1'b1;
        end else begin
          bin         <= i_bin;
          bcd         <= '0;
          ovf_pending <= i_bin > MAX_VAL;
          count       <= '0;
          o_busy      <= 1'b1;
        end
      end
      if (state == CONV) begin
        {bcd, bin} <= {adj, bin} << 1;
        count      <= count + 1'b1;
        if (last) begin
          // the final shift result is taken from the adjusted accumulator directly
          o_bcd   <= ovf_pending ? {DIGITS{4'h9}} : {adj[BW-2:0], bin[IN_W-1]};
          o_ovf   <= ovf_pending;
          o_valid <= 1'b1;
          o_busy  <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed checks of bin2bcd_seq latency, results, overflow, ignored starts and reset abort.
module tb_bin2bcd_seq;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic i_start = 1'b0;
  logic [31:0] i_bin = '0;
  logic o_busy, o_valid, o_ovf;
  logic [31:0] o_bcd;
`ifdef BIN2BCD_HEX_BYPASS_EN
  logic i_hex = 1'b0;
`endif
  int errors = 0;
  int checks = 0;

  bin2bcd_seq dut (
    .clk(clk),
    .reset(reset),
    .i_start(i_start),
`ifdef BIN2BCD_HEX_BYPASS_EN
    .i_hex(i_hex),
`endif
    .i_bin(i_bin),
    .o_busy(o_busy),
    .o_valid(o_valid),
    .o_ovf(o_ovf),
    .o_bcd(o_bcd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input string tag, input logic [31:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
    int n;
    int busy_cnt;
    n = 0;
    busy_cnt = 0;
    i_bin = v;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    while (!o_valid && n < 40) begin
      if (o_busy) busy_cnt++;
      tick();
      n++;
    end
    check({tag, "_lat"}, 64'(n), 64'd32);
    check({tag, "_busycyc"}, 64'(busy_cnt), 64'd32);
    check({tag, "_bcd"}, 64'(o_bcd), 64'(exp_bcd));
    check({tag, "_ovf"}, 64'(o_ovf), 64'(exp_ovf));
    check({tag, "_busy_end"}, 64'(o_busy), 64'd0);
    tick();
    check({tag, "_pulse"}, 64'(o_valid), 64'd0);
    check({tag, "_hold"}, 64'(o_bcd), 64'(exp_bcd));
  endtask

  initial begin
    int n;
    int pulses;
    tick();
    tick();
    check("rst_bcd", 64'(o_bcd), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_ovf", 64'(o_ovf), 64'd0);
    reset = 1'b0;
    tick();
    convert("zero", 32'd0, 32'h0000_0000, 1'b0);
    convert("d12345678", 32'h00BC_614E, 32'h1234_5678, 1'b0);
    convert("max", 32'd99999999, 32'h9999_9999, 1'b0);
    convert("ten", 32'd10, 32'h0000_0010, 1'b0);
    convert("d90817", 32'd90817, 32'h0009_0817, 1'b0);
    convert("ovf_min", 32'd100000000, 32'h9999_9999, 1'b1);
    convert("after_ovf", 32'd5, 32'h0000_0005, 1'b0);
    convert("ovf_all1", 32'hFFFF_FFFF, 32'h9999_9999, 1'b1);
    // start ignored while busy
    i_bin = 32'd1234;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    i_bin = 32'd5678;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    n = 10;
    while (!o_valid && n < 40) begin
      tick();
      n++;
    end
    check("ign_lat", 64'(n), 64'd32);
    check("ign_bcd", 64'(o_bcd), 64'h1234);
    check("ign_ovf", 64'(o_ovf), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_valid) pulses++;
    end
    check("ign_nopulse", 64'(pulses), 64'd0);
    check("ign_busy", 64'(o_busy), 64'd0);
    // reset aborts a conversion
    i_bin = 32'd777;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int i = 0; i < 14; i++) tick();
    check("abort_busy_pre", 64'(o_busy), 64'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 64'(o_busy), 64'd0);
    check("abort_bcd", 64'(o_bcd), 64'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      if (o_valid) pulses++;
      tick();
    end
    check("abort_nopulse", 64'(pulses), 64'd0);
    convert("after_abort", 32'd42, 32'h0000_0042, 1'b0);
    // start held high: one result every 33 cycles
    i_bin = 32'd7;
    i_start = 1'b1;
    n = 0;
    while (!o_valid && n < 40) begin
      tick();
      n++;
    end
    check("held_first", 64'(n), 64'd33);
    i_bin = 32'd250;
    n = 0;
    do begin
      tick();
      n++;
    end while (!o_valid && n < 40);
    i_start = 1'b0;
    check("held_period", 64'(n), 64'd33);
    check("held_bcd", 64'(o_bcd), 64'h250);
`ifdef BIN2BCD_HEX_BYPASS_EN
    tick();
    i_hex = 1'b1;
    i_bin = 32'hDEAD_BEEF;
    i_start = 1'b1;
    check("hex_busy_pre", 64'(o_busy), 64'd0);
    tick();
    i_start = 1'b0;
    i_hex = 1'b0;
    check("hex_valid", 64'(o_valid), 64'd1);
    check("hex_bcd", 64'(o_bcd), 64'hDEAD_BEEF);
    check("hex_ovf", 64'(o_ovf), 64'd0);
    check("hex_busy", 64'(o_busy), 64'd0);
    convert("after_hex", 32'd42, 32'h0000_0042, 1'b0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
